trap_ctrl: RTL
==============

# trap_ctrl

Trap sequencer in front of the machine-mode CSR file. It accepts ecall/ebreak/illegal/mret requests from the execute stage and, with `TRAP_MTIP_EN`, timer interrupts. It applies the required mepc/mcause/mstatus updates one write per cycle through the CSR file's single write port, then issues a one-cycle PC redirect. While idle it arbitrates that write port in favour of ordinary CSRRW/CSRRS instructions.

## Interface
- `XLEN`, 32, datapath width (equals `CPU_WIDTH`).
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, synchronous, active-low; clock `i_clk`.
- `i_req_valid` in 1: trap request from execute.
- `o_req_ready` out 1: controller idle; the request is accepted on `valid & ready`.
- `i_req_type` in 2: 00 ecall, 01 ebreak, 10 mret, 11 illegal instruction.
- `i_req_pc` in XLEN: PC of the trapping instruction.
- `i_inst_csr_wen`, `i_inst_csr_waddr[11:0]`, `i_inst_csr_wdata[XLEN]`: in, CSR-instruction write request.
- `o_inst_csr_gnt` out 1: instruction write forwarded this cycle.
- `o_csr_wen`, `o_csr_waddr[11:0]`, `o_csr_wdata[XLEN]`: out, CSR file write port.
- `o_csr_raddr` out 12: CSR file read address.
- `i_csr_rdata` in XLEN: combinational read data for `o_csr_raddr`.
- `o_stall` out 1: freeze fetch/decode.
- `o_redirect_valid` out 1: single-cycle pulse.
- `o_redirect_pc` out XLEN: new PC.
- `i_mtip`, `i_irq_pc_vld`, `i_irq_pc`, `i_mstatus[XLEN]`, `i_mie[XLEN]`: in, present only with `TRAP_MTIP_EN`.

## Operation
- States:
  - IDLE: accepts a request.
  - SAVE_EPC: writes 0x341 with the latched PC.
  - SAVE_CAUSE: writes 0x342 with the latched cause.
  - UPD_STATUS: reads and writes 0x300.
  - REDIR: reads the target CSR and pulses redirect.
- Exception (ecall/ebreak/illegal): IDLE→SAVE_EPC→SAVE_CAUSE→UPD_STATUS→REDIR→IDLE.
- mret: IDLE→UPD_STATUS→REDIR→IDLE.
- Causes: ecall 0x0000000B, ebreak 0x00000003, illegal 0x00000002, timer interrupt 0x80000007.
- Trap mstatus update: MPIE[7]←MIE[3], MIE←0, MPP[12:11]←11. All other bits are unchanged and taken from `i_csr_rdata`.
- mret mstatus update: MIE←MPIE, MPIE←1, MPP←11.
- REDIR target:
  - Traps: `o_csr_raddr`=0x305, `o_redirect_pc = i_csr_rdata & ~3` (direct mode only).
  - mret: `o_csr_raddr`=0x341, `o_redirect_pc = i_csr_rdata`.
- Type, PC and cause are latched at acceptance. Later changes on the inputs are ignored.
- Write port arbitration:
  - In IDLE, `o_csr_w*` mirror `i_inst_csr_*` and `o_inst_csr_gnt`=1.
  - In every other state the controller owns the port, `o_inst_csr_gnt`=0, and instruction writes are not forwarded. Execute is stalled, so none are pending.
- `o_csr_wen` is 0 in REDIR.
- `o_csr_raddr` is 0x300 outside UPD_STATUS and REDIR.

## Timing
- Reset values: state IDLE, `o_req_ready`=1, `o_stall`=0, `o_redirect_valid`=0, `o_redirect_pc`=0, latched registers 0.
- The CSR write port outputs are combinational; they mirror `i_inst_csr_*` in IDLE.
- Acceptance at edge N:
  - Exception: writes occur at edges N+1, N+2, N+3; `o_redirect_valid` is high during the cycle after edge N+3 (registered output).
  - mret: write at N+1; redirect in the following cycle.
- `o_stall` is high from the cycle after acceptance through the REDIR cycle inclusive. It is also asserted combinationally in the acceptance cycle (`i_req_valid & o_req_ready`).
- Back-to-back requests: a new request is accepted in the first IDLE cycle after REDIR, never during REDIR.
- Reset asserted mid-sequence: return to IDLE at the next edge. Partially completed CSR writes are not undone and no redirect is issued.
- `o_redirect_valid` is never high for two consecutive cycles.

## Configuration
- Macro: `TRAP_MTIP_EN`.
- Defined:
  - In IDLE with `!i_req_valid & i_irq_pc_vld & i_mtip & i_mstatus[3] & i_mie[7]`, the controller takes an interrupt.
  - It latches `i_irq_pc` as EPC and cause 0x80000007, then runs the exception path.
  - A synchronous request in the same cycle wins; the interrupt waits.
- Undefined:
  - The interrupt ports do not exist.
  - Only `i_req_valid` starts a sequence.

## Structure
- Package `trap_pkg`:
  - State encoding typedef.
  - CSR addresses: MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342.
  - Cause constants.
  - Request type codes.
- Sub-module `trap_status_calc`: combinational; takes old mstatus plus an is_mret flag and produces the new mstatus. It is instantiated once.

## Test plan
- ecall at PC 0x80000010, mtvec=0x80000100, mstatus=0x1808:
  - Writes in order: mepc←0x80000010, mcause←0xB, mstatus←0x1880.
  - Redirect to 0x80000100 exactly 4 cycles after acceptance.
- mret with mepc=0x80000014, mstatus=0x1880: mstatus←0x1888, then redirect to 0x80000014 two cycles after acceptance.
- Instruction CSRRW to 0x305 data 0x80000200 while IDLE: forwarded with `gnt`=1.
- Instruction write presented during SAVE_CAUSE: not forwarded, `gnt`=0.
- Reset asserted in SAVE_CAUSE: IDLE next cycle, no redirect pulse, `o_req_ready`=1.
- `TRAP_MTIP_EN`:
  - `i_mtip`=1, MIE=1, MTIE=1, `i_irq_pc`=0x80000040: mcause←0x80000007, mepc←0x80000040.
  - Same cycle with an ecall request: the ecall is serviced first.

Source files
------------

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the machine-mode trap sequencer:
//   - sequencer state encoding
//   - machine CSR addresses used by the sequencer
//   - mstatus / mie bit positions
//   - request type codes and mcause values
//   - req_cause(): maps a synchronous request type to its mcause value
// -----------------------------------------------------------------------------
package trap_pkg;

  localparam int CPU_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAVE_EPC   = 3'd1,
    ST_SAVE_CAUSE = 3'd2,
    ST_UPD_STATUS = 3'd3,
    ST_REDIR      = 3'd4
  } trap_state_e;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus / mie bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MTIE       = 7;

  // Request type codes from execute
  localparam logic [1:0] REQ_ECALL   = 2'b00;
  localparam logic [1:0] REQ_EBREAK  = 2'b01;
  localparam logic [1:0] REQ_MRET    = 2'b10;
  localparam logic [1:0] REQ_ILLEGAL = 2'b11;

  // mcause values
  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL   = 32'h0000_000B;
  localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK  = 32'h0000_0003;
  localparam logic [CPU_WIDTH-1:0] CAUSE_ILLEGAL = 32'h0000_0002;
  localparam logic [CPU_WIDTH-1:0] CAUSE_MTIMER  = 32'h8000_0007;

  // mret writes no mcause, so its entry is a don't-care zero.
  function automatic logic [CPU_WIDTH-1:0] req_cause(input logic [1:0] req_type);
    logic [CPU_WIDTH-1:0] cause;
    case (req_type)
      REQ_ECALL:   cause = CAUSE_ECALL;
      REQ_EBREAK:  cause = CAUSE_EBREAK;
      REQ_ILLEGAL: cause = CAUSE_ILLEGAL;
      default:     cause = '0;
    endcase
    return cause;
  endfunction

endpackage

// File: rtl/trap_status_calc.sv
// -----------------------------------------------------------------------------
// trap_status_calc
// Combinational mstatus update for trap entry and mret.
//   Trap entry: MPIE <- MIE, MIE <- 0, MPP <- 2'b11
//   mret      : MIE <- MPIE, MPIE <- 1, MPP <- 2'b11
// All other bits pass through unchanged.
// Ports:
//   old_status  in  XLEN  current mstatus value
//   is_mret     in  1     select the mret update instead of trap entry
//   new_status  out XLEN  updated mstatus value
// -----------------------------------------------------------------------------
module trap_status_calc
  import trap_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH
) (
  input  logic [XLEN-1:0] old_status,
  input  logic            is_mret,
  output logic [XLEN-1:0] new_status
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through it can leave a value held, which would infer a latch.
  always_comb begin
    new_status = old_status;
    new_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    if (is_mret) begin
      new_status[MSTATUS_MIE]  = old_status[MSTATUS_MPIE];
      new_status[MSTATUS_MPIE] = 1'b1;
    end else begin
      new_status[MSTATUS_MPIE] = old_status[MSTATUS_MIE];
      new_status[MSTATUS_MIE]  = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Trap sequencer in front of the machine-mode CSR file. Accepts ecall, ebreak,
// illegal-instruction and mret requests from execute, writes mepc / mcause /
// mstatus one per cycle through the CSR file's single write port, then pulses
// a one-cycle PC redirect. While idle the write port is handed to ordinary
// CSR instructions.
//
// Optional feature macro: TRAP_MTIP_EN
//   Defined  : machine timer interrupts are taken from IDLE when enabled in
//              mstatus.MIE and mie.MTIE; a synchronous request in the same
//              cycle has priority.
//   Undefined: interrupt ports are absent; only i_req_valid starts a sequence.
//
// Ports:
//   i_clk, i_rst_n          clock, synchronous active-low reset
//   i_req_valid/o_req_ready trap request handshake (ready == idle)
//   i_req_type, i_req_pc    request type code and PC of trapping instruction
//   i_mtip, i_irq_pc_vld,
//   i_irq_pc, i_mstatus,
//   i_mie                   timer interrupt inputs (TRAP_MTIP_EN only)
//   i_inst_csr_*            CSR instruction write request
//   o_inst_csr_gnt          instruction write forwarded this cycle
//   o_csr_wen/waddr/wdata   CSR file write port (combinational)
//   o_csr_raddr,i_csr_rdata CSR file read port (combinational read data)
//   o_stall                 freeze fetch/decode
//   o_redirect_valid/pc     single-cycle PC redirect
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN = CPU_WIDTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,

  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_type,
  input  logic [XLEN-1:0] i_req_pc,

`ifdef TRAP_MTIP_EN
  input  logic            i_mtip,
  input  logic            i_irq_pc_vld,
  input  logic [XLEN-1:0] i_irq_pc,
  input  logic [XLEN-1:0] i_mstatus,
  input  logic [XLEN-1:0] i_mie,
`endif

  input  logic            i_inst_csr_wen,
  input  logic [11:0]     i_inst_csr_waddr,
  input  logic [XLEN-1:0] i_inst_csr_wdata,
  output logic            o_inst_csr_gnt,

  output logic            o_csr_wen,
  output logic [11:0]     o_csr_waddr,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic [11:0]     o_csr_raddr,
  input  logic [XLEN-1:0] i_csr_rdata,

  output logic            o_stall,
  output logic            o_redirect_valid,
  output logic [XLEN-1:0] o_redirect_pc
);

  trap_state_e     state_q, state_d;
  logic            is_mret_q;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic            redirect_q;

  logic            idle;
  logic            req_accept;
  logic            irq_take;
  logic [XLEN-1:0] status_new;

  assign idle       = (state_q == ST_IDLE);
  assign req_accept = i_req_valid & idle;

`ifdef TRAP_MTIP_EN
  // A synchronous request in the same cycle wins; the interrupt stays
  // pending on its inputs and is taken from a later IDLE cycle.
  assign irq_take = idle & ~i_req_valid & i_irq_pc_vld & i_mtip
                  & i_mstatus[MSTATUS_MIE] & i_mie[MIE_MTIE];

  logic unused_irq_bits;
  assign unused_irq_bits = ^{i_mstatus[XLEN-1:MSTATUS_MIE+1], i_mstatus[MSTATUS_MIE-1:0],
                             i_mie[XLEN-1:MIE_MTIE+1], i_mie[MIE_MTIE-1:0]};
`else
  assign irq_take = 1'b0;
`endif

  trap_status_calc #(
    .XLEN (XLEN)
  ) u_status_calc (
    .old_status (i_csr_rdata),
    .is_mret    (is_mret_q),
    .new_status (status_new)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_accept) begin
          state_d = (i_req_type == REQ_MRET) ? ST_UPD_STATUS : ST_SAVE_EPC;
        end else if (irq_take) begin
          state_d = ST_SAVE_EPC;
        end
      end
      ST_SAVE_EPC:   state_d = ST_SAVE_CAUSE;
      ST_SAVE_CAUSE: state_d = ST_UPD_STATUS;
      ST_UPD_STATUS: state_d = ST_REDIR;
      ST_REDIR:      state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // CSR port, stall and redirect target
  // ---------------------------------------------------------------------------
  always_comb begin
    o_csr_wen      = 1'b0;
    o_csr_waddr    = CSR_MSTATUS;
    o_csr_wdata    = '0;
    o_csr_raddr    = CSR_MSTATUS;
    o_inst_csr_gnt = 1'b0;
    o_redirect_pc  = '0;
    unique case (state_q)
      ST_IDLE: begin
        // Execute only issues CSR writes while no trap is in flight, so in
        // IDLE the port is simply passed through.
        o_csr_wen      = i_inst_csr_wen;
        o_csr_waddr    = i_inst_csr_waddr;
        o_csr_wdata    = i_inst_csr_wdata;
        o_inst_csr_gnt = 1'b1;
      end
      ST_SAVE_EPC: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CSR_MEPC;
        o_csr_wdata = epc_q;
      end
      ST_SAVE_CAUSE: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CSR_MCAUSE;
        o_csr_wdata = cause_q;
      end
      ST_UPD_STATUS: begin
        o_csr_wen   = 1'b1;
        o_csr_waddr = CSR_MSTATUS;
        o_csr_wdata = status_new;
        o_csr_raddr = CSR_MSTATUS;
      end
      ST_REDIR: begin
        if (is_mret_q) begin
          o_csr_raddr   = CSR_MEPC;
          o_redirect_pc = i_csr_rdata;
        end else begin
          // Direct mode only: the mode bits of mtvec are dropped.
          o_csr_raddr   = CSR_MTVEC;
          o_redirect_pc = {i_csr_rdata[XLEN-1:2], 2'b00};
        end
      end
      default: ;
    endcase
  end

  assign o_req_ready      = idle;
  assign o_stall          = ~idle | req_accept | irq_take;
  assign o_redirect_valid = redirect_q;

  // ---------------------------------------------------------------------------
  // State and request capture
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      is_mret_q  <= 1'b0;
      epc_q      <= '0;
      cause_q    <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // REDIR always falls back to IDLE, so this pulse lasts one cycle.
      redirect_q <= (state_d == ST_REDIR);
      if (req_accept) begin
        is_mret_q <= (i_req_type == REQ_MRET);
        epc_q     <= i_req_pc;
        cause_q   <= req_cause(i_req_type);
      end
`ifdef TRAP_MTIP_EN
      else if (irq_take) begin
        is_mret_q <= 1'b0;
        epc_q     <= i_irq_pc;
        cause_q   <= CAUSE_MTIMER;
      end
`endif
    end
  end

endmodule
